// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg: shared types and constants for the single-port RAM arbiter.
// Holds the per-port request bundle and stall-counter sizing.
package sp_ram_arb_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int MAX_PORTS   = 8;
  localparam int REQ_ADDR_W  = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
  } ram_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with same-cycle one-hot grant.
// Ports: clk, rst_n, req (NUM_PORTS), gnt (one-hot), idx (winner index).
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               j;

  // Scan from the port after the last winner, wrapping around.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      j = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NUM_PORTS - 1);
    end else if (found) begin
      ptr_q <= idx;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: shares one single-port word RAM among NUM_PORTS requesters.
// Ports: req/addr/we/be/wdata in, gnt/rvalid/rdata out, ram_* to sp_ram,
// stall_clr_i/stall_cnt_o live only with SP_RAM_ARB_STALL_CNT_EN defined.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 2,
  parameter int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][3:0]             be_i,
  input  logic [NUM_PORTS-1:0][31:0]            wdata_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [31:0]                           rdata_o,
  output logic                                  ram_en_o,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_o,
  output logic                                  ram_we_o,
  output logic [3:0]                            ram_be_o,
  output logic [31:0]                           ram_wdata_o,
  input  logic [31:0]                           ram_rdata_i,
  input  logic                                  stall_clr_i,
  output logic [NUM_PORTS-1:0][STALL_CNT_W-1:0] stall_cnt_o
);

  logic [IDX_W-1:0]     win_idx;
  logic [NUM_PORTS-1:0] rvalid_q;
  ram_req_t             req_v [NUM_PORTS];
  ram_req_t             win;
  logic                 unused_bits;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_i),
    .gnt   (gnt_o),
    .idx   (win_idx)
  );

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      req_v[k].addr  = REQ_ADDR_W'(addr_i[k]);
      req_v[k].we    = we_i[k];
      req_v[k].be    = be_i[k];
      req_v[k].wdata = wdata_i[k];
    end
  end

  assign win = req_v[win_idx];

  // RAM side is quiet (all zero) whenever nobody requests.
  always_comb begin
    ram_en_o    = |req_i;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_wdata_o = '0;
    if (ram_en_o) begin
      ram_addr_o  = win.addr[ADDR_WIDTH-1:0];
      ram_we_o    = win.we;
      ram_be_o    = win.we ? win.be : 4'h0;
      ram_wdata_o = win.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = ram_rdata_i;

`ifdef SP_RAM_ARB_STALL_CNT_EN
  logic [NUM_PORTS-1:0][STALL_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (stall_clr_i) begin
          cnt_q[k] <= '0;
        end else if (req_i[k] && !gnt_o[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign stall_cnt_o = cnt_q;
  assign unused_bits = ^win.addr;
`else
  assign stall_cnt_o = '0;
  assign unused_bits = ^{win.addr, stall_clr_i};
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed stimulus with a response scoreboard.
// A behavioural sp_ram sits behind the arbiter's RAM port.
module tb_sp_ram_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_i;
  logic [1:0][7:0]  addr_i;
  logic [1:0]       we_i;
  logic [1:0][3:0]  be_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             ram_en_o;
  logic [7:0]       ram_addr_o;
  logic             ram_we_o;
  logic [3:0]       ram_be_o;
  logic [31:0]      ram_wdata_o;
  logic [31:0]      ram_rdata_i;
  logic             stall_clr_i;
  logic [1:0][15:0] stall_cnt_o;

  logic [31:0] mem [256];

  typedef struct {
    int          due;
    logic [1:0]  vld;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   errors;
  int   checks;

  always #5 clk = ~clk;

  sp_ram_arbiter #(
    .ADDR_WIDTH (8),
    .NUM_PORTS  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .stall_clr_i (stall_clr_i),
    .stall_cnt_o (stall_cnt_o)
  );

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever a response is due.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rvalid_missing: got none expected %h", q[0].vld);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid", 32'(rvalid_o), 32'(e.vld));
        if (e.rd) chk("rdata", rdata_o, e.data);
      end else if (rvalid_o != 2'b00) begin
        chk("rvalid_spurious", 32'(rvalid_o), 32'h0);
      end
    end
  end

  // Drive one cycle; check the grant; queue the expected response.
  task automatic step(input logic [1:0] req, input logic [7:0] a0,
                      input logic [7:0] a1, input logic [1:0] we,
                      input logic [3:0] be1, input logic [31:0] wd1,
                      input logic [1:0] egnt, input logic [31:0] edata,
                      input logic push);
    exp_t e;
    req_i      = req;
    addr_i[0]  = a0;
    addr_i[1]  = a1;
    we_i       = we;
    be_i[0]    = 4'hF;
    be_i[1]    = be1;
    wdata_i[0] = 32'h0BAD_0BAD;
    wdata_i[1] = wd1;
    @(negedge clk);
    chk("gnt", 32'(gnt_o), 32'(egnt));
    chk("ram_en", 32'(ram_en_o), 32'(req != 2'b00));
    if (push && egnt != 2'b00) begin
      e.due  = cyc + 1;
      e.vld  = egnt;
      e.rd   = ~|(we & egnt);
      e.data = edata;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] G0 = 2'b01;
  localparam logic [1:0] G1 = 2'b10;

  initial begin
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    req_i       = '0;
    addr_i      = '0;
    we_i        = '0;
    be_i        = '0;
    wdata_i     = '0;
    stall_clr_i = 1'b0;
    ram_rdata_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[8'h10] = 32'h1122_3344;

    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_stall", 32'(stall_cnt_o), 32'h0);
    chk("rst_ram_en", 32'(ram_en_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone p0 read with be=F: grant at once, RAM sees no byte enables.
    req_i = G0; addr_i[0] = 8'h05; we_i = 2'b00; be_i[0] = 4'hF;
    #1;
    chk("rd_be_zero", 32'(ram_be_o), 32'h0);
    chk("rd_we_zero", 32'(ram_we_o), 32'h0);
    chk("rd_addr", 32'(ram_addr_o), 32'h05);
    step(G0, 8'h05, 8'h00, 2'b00, 4'h0, 0, G0, 32'h1000_0005, 1);
    step(G1, 8'h00, 8'h03, 2'b00, 4'h0, 0, G1, 32'h1000_0003, 1);

    // Continuous contention alternates starting from port 0.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(2'b11, 8'h01, 8'h02, 2'b00, 4'h0, 0, G0, 32'h1000_0001, 1);
      else
        step(2'b11, 8'h01, 8'h02, 2'b00, 4'h0, 0, G1, 32'h1000_0002, 1);
    end

    step(2'b00, 8'h00, 8'h00, 2'b00, 4'h0, 0, 2'b00, 0, 1);
    chk("idle_addr", 32'(ram_addr_o), 32'h0);
`ifdef SP_RAM_ARB_STALL_CNT_EN
    chk("stall_p0", 32'(stall_cnt_o[0]), 32'd3);
    chk("stall_p1", 32'(stall_cnt_o[1]), 32'd3);
    stall_clr_i = 1'b1;
    @(posedge clk);
    #1;
    stall_clr_i = 1'b0;
    chk("stall_clr", 32'(stall_cnt_o), 32'h0);
`else
    chk("stall_tied", 32'(stall_cnt_o), 32'h0);
`endif

    // Partial write from p1, then read-back from p0.
    req_i = G1; addr_i[1] = 8'h10; we_i = 2'b10; be_i[1] = 4'b0011;
    wdata_i[1] = 32'hDEAD_BEEF;
    #1;
    chk("wr_we", 32'(ram_we_o), 32'h1);
    chk("wr_be", 32'(ram_be_o), 32'h3);
    chk("wr_data", ram_wdata_o, 32'hDEAD_BEEF);
    chk("wr_addr", 32'(ram_addr_o), 32'h10);
    step(G1, 8'h00, 8'h10, 2'b10, 4'b0011, 32'hDEAD_BEEF, G1, 0, 1);
    step(G0, 8'h10, 8'h00, 2'b00, 4'h0, 0, G0, 32'h1122_BEEF, 1);
    step(G0, 8'h05, 8'h00, 2'b00, 4'h0, 0, G0, 32'h1000_0005, 1);

    // Reset while a response is pending: it must vanish.
    step(G0, 8'h07, 8'h00, 2'b00, 4'h0, 0, G0, 0, 0);
    chk("pre_rst_rvalid", 32'(rvalid_o), 32'(G0));
    req_i = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(rvalid_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b11, 8'h08, 8'h09, 2'b00, 4'h0, 0, G0, 32'h1000_0008, 1);
    step(2'b11, 8'h08, 8'h09, 2'b00, 4'h0, 0, G1, 32'h1000_0009, 1);
    step(2'b00, 8'h00, 8'h00, 2'b00, 4'h0, 0, 2'b00, 0, 1);
    step(2'b00, 8'h00, 8'h00, 2'b00, 4'h0, 0, 2'b00, 0, 1);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
